// File: rtl/joybus_tx.sv
// Joybus serial transmitter: serializes up to 32 bits plus a stop bit onto the
// open-drain N64 controller line. Drives output-enable-low only, with collision detection.
module joybus_tx #(
    parameter int CLKS_PER_US = 4,
    parameter int GUARD_CLKS  = 16,
    parameter int COLL_MASK   = 3
) (
    input  logic        CTRL_CLK,
    input  logic        CTRL_RST,
    input  logic        tx_start_i,
    input  logic [31:0] tx_data_i,
    input  logic [5:0]  tx_len_i,
    input  logic        stop_type_i,
    input  logic        tx_abort_i,
    input  logic        CTRL_i,
    output logic        ctrl_drv_low_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        collision_o
);

    // Phase counters are loaded with (duration - 1) and count down to zero.
    localparam logic [7:0] U1_M1      = 8'(CLKS_PER_US - 1);
    localparam logic [7:0] U2_M1      = 8'(2 * CLKS_PER_US - 1);
    localparam logic [7:0] U3_M1      = 8'(3 * CLKS_PER_US - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CLKS - 1);
    localparam logic [7:0] COLL_START = 8'(COLL_MASK);

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        LOW,
        HIGH,
        STOP_LOW,
        STOP_HIGH
    } state_t;

    state_t      state;
    logic        sync_meta;
    logic        sync_q;
    logic [31:0] data_q;
    logic [5:0]  bits_left;
    logic        stop_type_q;
    logic [7:0]  phase_cnt;
    logic [7:0]  guard_cnt;
    logic [7:0]  rel_cnt;

    logic        collide;
    logic [7:0]  stop_low_len;

    assign collide      = (rel_cnt >= COLL_START) && !sync_q;
    assign stop_low_len = stop_type_q ? U2_M1 : U1_M1;

    // NOTE: every register here is updated with <= so all of them see the values
    // from before the edge; blocking assignments would make the order of statements matter.
    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            // NOTE: sync flops reset to 1 (idle line) so a fresh start is not
            // delayed by a phantom low; the payload register needs no reset.
            state          <= IDLE;
            sync_meta      <= 1'b1;
            sync_q         <= 1'b1;
            bits_left      <= '0;
            stop_type_q    <= 1'b0;
            phase_cnt      <= '0;
            guard_cnt      <= '0;
            rel_cnt        <= '0;
            ctrl_drv_low_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            collision_o    <= 1'b0;
        end else begin
            sync_meta   <= CTRL_i;
            sync_q      <= sync_meta;
            done_o      <= 1'b0;
            collision_o <= 1'b0;

            if (state != IDLE && tx_abort_i) begin
                state          <= IDLE;
                ctrl_drv_low_o <= 1'b0;
                busy_o         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_start_i && !tx_abort_i) begin
                            data_q      <= tx_data_i;
                            bits_left   <= (tx_len_i > 6'd32) ? 6'd32 : tx_len_i;
                            stop_type_q <= stop_type_i;
                            guard_cnt   <= '0;
                            busy_o      <= 1'b1;
                            state       <= GUARD;
                        end
                    end

                    // Wait for GUARD_CLKS consecutive high samples before touching the line.
                    GUARD: begin
                        if (!sync_q) begin
                            guard_cnt <= '0;
                        end else if (guard_cnt == GUARD_LAST) begin
                            ctrl_drv_low_o <= 1'b1;
                            if (bits_left == 6'd0) begin
                                state     <= STOP_LOW;
                                phase_cnt <= stop_low_len;
                            end else begin
                                state     <= LOW;
                                phase_cnt <= data_q[0] ? U1_M1 : U3_M1;
                            end
                        end else begin
                            guard_cnt <= guard_cnt + 8'd1;
                        end
                    end

                    LOW: begin
                        if (phase_cnt != 8'd0) begin
                            phase_cnt <= phase_cnt - 8'd1;
                        end else begin
                            ctrl_drv_low_o <= 1'b0;
                            rel_cnt        <= '0;
                            phase_cnt      <= data_q[0] ? U3_M1 : U1_M1;
                            state          <= HIGH;
                        end
                    end

                    HIGH: begin
                        if (collide) begin
                            collision_o <= 1'b1;
                            busy_o      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            if (rel_cnt != 8'hFF)
                                rel_cnt <= rel_cnt + 8'd1;
                            if (phase_cnt != 8'd0) begin
                                phase_cnt <= phase_cnt - 8'd1;
                            end else begin
                                // Next bit's low starts back-to-back so the bit period stays 4u.
                                data_q         <= data_q >> 1;
                                bits_left      <= bits_left - 6'd1;
                                ctrl_drv_low_o <= 1'b1;
                                if (bits_left == 6'd1) begin
                                    state     <= STOP_LOW;
                                    phase_cnt <= stop_low_len;
                                end else begin
                                    state     <= LOW;
                                    phase_cnt <= data_q[1] ? U1_M1 : U3_M1;
                                end
                            end
                        end
                    end

                    STOP_LOW: begin
                        if (phase_cnt != 8'd0) begin
                            phase_cnt <= phase_cnt - 8'd1;
                        end else begin
                            ctrl_drv_low_o <= 1'b0;
                            rel_cnt        <= '0;
                            phase_cnt      <= U2_M1;
                            state          <= STOP_HIGH;
                        end
                    end

                    STOP_HIGH: begin
                        if (collide) begin
                            collision_o <= 1'b1;
                            busy_o      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            if (rel_cnt != 8'hFF)
                                rel_cnt <= rel_cnt + 8'd1;
                            if (phase_cnt != 8'd0) begin
                                phase_cnt <= phase_cnt - 8'd1;
                            end else begin
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end

                    default: begin
                        ctrl_drv_low_o <= 1'b0;
                        busy_o         <= 1'b0;
                        state          <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joybus_tx.sv
// Directed bench for joybus_tx: the line is looped back through an open-drain model
// with an injectable external pull-down; waveforms are decoded into low/high run lengths.
module tb_joybus_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        stop_type = 1'b0;
    logic        tx_abort = 1'b0;
    logic        ext_high = 1'b1;
    logic        ctrl_line;
    logic        drv;
    logic        busy;
    logic        done;
    logic        coll;

    int n_vec  = 0;
    int n_miss = 0;

    assign ctrl_line = ~drv & ext_high;

    joybus_tx #(
        .CLKS_PER_US(4),
        .GUARD_CLKS (16),
        .COLL_MASK  (3)
    ) dut (
        .CTRL_CLK      (clk),
        .CTRL_RST      (rst),
        .tx_start_i    (tx_start),
        .tx_data_i     (tx_data),
        .tx_len_i      (tx_len),
        .stop_type_i   (stop_type),
        .tx_abort_i    (tx_abort),
        .CTRL_i        (ctrl_line),
        .ctrl_drv_low_o(drv),
        .busy_o        (busy),
        .done_o        (done),
        .collision_o   (coll)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Request a frame at a negedge; returns at the negedge after the accepting edge.
    task automatic start_frame(input logic [31:0] d, input logic [5:0] l, input logic st);
        tx_data   = d;
        tx_len    = l;
        stop_type = st;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_drv(output int cnt);
        cnt = 0;
        while (!drv && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Called at the first negedge where the line is driven low; records the frame until done.
    task automatic capture(input logic [31:0] d, input int nbits, input logic st,
                           input int exp_total, input logic [31:0] exp_word);
        int          lows[40];
        int          highs[40];
        int          idx = 0;
        int          run = 0;
        int          total = 0;
        int          coll_seen = 0;
        logic        level = 1'b1;
        logic        got_done = 1'b0;
        logic [31:0] word = '0;

        if (!drv) begin
            check("first_low_timeout", 0, 1);
            return;
        end
        for (int c = 0; c < 1200 && !got_done; c++) begin
            if (coll)
                coll_seen++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                total++;
                if (drv == level) begin
                    run++;
                end else begin
                    if (level) begin
                        if (idx < 40) lows[idx] = run;
                    end else begin
                        if (idx < 40) highs[idx] = run;
                        idx++;
                    end
                    level = drv;
                    run   = 1;
                end
                @(negedge clk);
            end
        end
        if (idx < 40) highs[idx] = run;

        check("done_seen", got_done, 1);
        check("frame_cycles", total, exp_total);
        check("bit_count", idx, nbits);
        check("no_collision", coll_seen, 0);
        if (idx == nbits) begin
            for (int i = 0; i < nbits; i++) begin
                check($sformatf("bit%0d_low", i), lows[i], d[i] ? 4 : 12);
                check($sformatf("bit%0d_high", i), highs[i], d[i] ? 12 : 4);
                if (lows[i] < highs[i])
                    word[i] = 1'b1;
            end
            check("stop_low", lows[nbits], st ? 8 : 4);
            check("stop_high", highs[nbits], 8);
        end
        check("sniffed_word", word, exp_word);
        check("busy_fall_with_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int lat;
        int bad;
        int seen;
        int rises;
        logic prev;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_drv", drv, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coll", coll, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Console poll, command 0x01: seven '0' bits then one '1', console stop.
        start_frame(32'h0000_0080, 6'd8, 1'b0);
        wait_drv(lat);
        check("guard_latency", lat, 16);
        capture(32'h0000_0080, 8, 1'b0, 140, 32'h0000_0080);

        // 32 ones with controller stop.
        start_frame(32'hFFFF_FFFF, 6'd32, 1'b1);
        wait_drv(lat);
        check("guard_latency_32", lat, 16);
        capture(32'hFFFF_FFFF, 32, 1'b1, 528, 32'hFFFF_FFFF);

        // Line held low externally: no driving, guard restarts, starts while busy ignored.
        ext_high = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(32'h0000_00A5, 6'd8, 1'b0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tx_start = (c == 10 || c == 50);
            tx_data  = 32'hFFFF_FFFF;
            tx_len   = 6'd3;
            if (drv || coll || !busy)
                bad++;
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("guard_hold_low", bad, 0);
        ext_high = 1'b1;
        wait_drv(lat);
        check("guard_after_release", lat, 18);
        capture(32'h0000_00A5, 8, 1'b0, 140, 32'h0000_00A5);

        // External low 6 cycles into the high phase of a '1' bit.
        start_frame(32'h0000_00FF, 6'd8, 1'b0);
        wait_drv(lat);
        for (int k = 0; k < 10 && drv; k++)
            @(negedge clk);
        repeat (5) @(negedge clk);
        ext_high = 1'b0;
        seen = 0;
        for (int k = 0; k < 12 && seen == 0; k++) begin
            @(negedge clk);
            if (coll)
                seen = 1;
        end
        check("collision_pulse", seen, 1);
        check("collision_drv", drv, 0);
        check("collision_busy", busy, 0);
        @(negedge clk);
        check("collision_one_cycle", coll, 0);
        ext_high = 1'b1;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (done || drv || busy)
                bad++;
            @(negedge clk);
        end
        check("collision_no_done", bad, 0);

        // Reset while bit 5 is being driven low, then a clean frame.
        start_frame(32'h0000_0000, 6'd8, 1'b0);
        wait_drv(lat);
        rises = 1;
        prev  = 1'b1;
        for (int c = 0; c < 200 && rises < 6; c++) begin
            @(negedge clk);
            if (drv && !prev)
                rises++;
            prev = drv;
        end
        check("reached_bit5", rises, 6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_drv", drv, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(32'h0000_0001, 6'd8, 1'b0);
        wait_drv(lat);
        check("guard_after_rst", lat, 16);
        capture(32'h0000_0001, 8, 1'b0, 140, 32'h0000_0001);

        // Abort mid-frame, then abort together with start in IDLE.
        start_frame(32'h0000_000F, 6'd8, 1'b1);
        wait_drv(lat);
        repeat (20) @(negedge clk);
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        check("abort_drv", drv, 0);
        check("abort_busy", busy, 0);
        check("abort_flags", {30'd0, done, coll}, 0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (done || drv || coll || busy)
                bad++;
            @(negedge clk);
        end
        check("abort_quiet", bad, 0);
        tx_abort = 1'b1;
        tx_start = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        tx_start = 1'b0;
        check("abort_start_idle", busy, 0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (drv || busy)
                bad++;
            @(negedge clk);
        end
        check("abort_start_quiet", bad, 0);

        // Stop bit only.
        start_frame(32'hDEAD_BEEF, 6'd0, 1'b0);
        wait_drv(lat);
        check("guard_latency_len0", lat, 16);
        capture(32'h0000_0000, 0, 1'b0, 12, 32'h0000_0000);

        // Length above 32 saturates.
        start_frame(32'h1234_5678, 6'd40, 1'b1);
        wait_drv(lat);
        capture(32'h1234_5678, 32, 1'b1, 528, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/joybus_tx.md
Name: joybus_tx

Overview:
- Joybus serial transmitter, the sending end of the N64 controller line that the controller sniffer receives.
- Serializes up to 32 data bits plus a stop bit onto the open-drain CTRL line. Used for console-side polling (command 0x01) and controller-response emulation.
- Sits in the CTRL_CLK domain next to the sniffer. The pad is driven as output-enable-low only.

Parameters:
- CLKS_PER_US, 4, CTRL_CLK cycles per joybus microsecond unit (u); range 2..63.
- GUARD_CLKS, 16, consecutive synchronized-high cycles on CTRL_i required before driving; range 1..255.
- COLL_MASK, 3, cycles after each line release during which CTRL_i is not checked (covers sync plus rise time).

Ports:
- CTRL_CLK  in  1  sole clock.
- CTRL_RST  in  1  synchronous, active-high reset.
- tx_start_i  in  1  request; sampled only in IDLE.
- tx_data_i  in  32  payload; bit 0 goes on the wire first, which matches the sniffer's storage order.
- tx_len_i  in  6  number of data bits; 0 = stop bit only; values above 32 are treated as 32.
- stop_type_i  in  1  stop-bit shape. 0 = console stop (1u low, 2u high). 1 = controller stop (2u low, 2u high).
- tx_abort_i  in  1  forces line release and return to IDLE.
- CTRL_i  in  1  asynchronous line monitor; 2-FF synchronized internally.
- ctrl_drv_low_o  out  1  1 = pull line low; 0 = release. Registered.
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE.
- done_o  out  1  one-cycle pulse after the stop bit completes.
- collision_o  out  1  one-cycle pulse when the line is low while released.

Behaviour:
- Reset values (CTRL_RST=1 at a clock edge): ctrl_drv_low_o=0, busy_o=0, done_o=0, collision_o=0. State=IDLE, counters=0, sync FFs=1. A reset mid-frame releases the line on the next edge.
- Encoding, one bit = 4u:
  - '0' = 3u low, 1u high.
  - '1' = 1u low, 3u high.
  - Stop bit as selected by stop_type_i.
- States:
  - IDLE:
    - On tx_start_i=1, latch data, len (saturated) and stop_type; go to GUARD.
    - busy_o rises next cycle.
    - tx_start_i is ignored in every state other than IDLE.
  - GUARD:
    - Guard counter increments while the synchronized CTRL_i=1 and clears to 0 when it is 0.
    - When the counter reaches GUARD_CLKS-1 with the line high, go to LOW. ctrl_drv_low_o=1 from the next cycle.
    - If len=0, go to STOP_LOW instead.
    - No timeout; waits until idle or abort.
  - LOW:
    - Drive low for 1u ('1') or 3u ('0'), or 1u/2u for the stop bit.
    - Then release and go to HIGH (or STOP_HIGH).
  - HIGH:
    - Release for 3u ('1') or 1u ('0').
    - Then shift the data right, decrement the bit count, and go to LOW or STOP_LOW.
    - No idle cycles between bits: the bit period is exactly 4*CLKS_PER_US.
  - STOP_LOW / STOP_HIGH:
    - Stop-bit shape as selected.
    - At the end of STOP_HIGH: done_o=1 for one cycle, busy_o=0 in the same cycle, state=IDLE.
- Latency:
  - Start accepted at cycle t; the earliest first low is at t+1+GUARD_CLKS, when the line is already high.
  - Frame length from first low to done = len*4u + 3u (console) or 4u (controller) cycles.
- Collision:
  - In HIGH/STOP_HIGH, after COLL_MASK cycles since release, a synchronized CTRL_i=0 causes:
    - collision_o pulse;
    - line stays released;
    - return to IDLE, with no done_o.
  - A low line is not treated as a collision in GUARD.
- Abort:
  - tx_abort_i=1 in any non-IDLE state: next cycle ctrl_drv_low_o=0, busy_o=0, state=IDLE, no done_o or collision_o.
  - Abort wins over collision and done in the same cycle.
  - Abort and start together in IDLE: start is ignored.
- Counter width: ≥8 bits for phase counting (3u max = 189 cycles). Bit counter is 6 bits.

Test Plan:
- Command 0x01 (CLKS_PER_US=4, tx_data_i[7:0]=8'b10000000, len=8, stop_type=0, line idle) -> after guard:
  - 7 bits of 12 low/4 high;
  - 1 bit of 4 low/12 high;
  - stop bit 4 low/8 high;
  - done_o exactly 140 cycles after the first low.
- len=32, data=32'hFFFFFFFF, stop_type=1 -> 32 bits of 4 low/12 high, then 8 low/8 high; done at cycle 528; loop the line into the sniffer model and it captures 32'hFFFFFFFF.
- CTRL_i held low for 100 cycles after start -> ctrl_drv_low_o stays 0; first low occurs GUARD_CLKS+sync cycles after release; tx_start_i pulses while busy are ignored.
- External low injected 6 cycles into a '1' HIGH phase -> collision_o pulse, line released, busy_o=0, no done_o.
- CTRL_RST asserted at bit 5 while low is driven -> next edge: ctrl_drv_low_o=0, busy_o=0; a new start transmits a clean frame.
- len=0 -> stop bit only (12 cycles console), then done. len=40 -> behaves as 32 (528 cycles with controller stop).
